countdown_multi: RTL and testbench

Multi-channel countdown timer bank: CHANNELS independent down-counters of WIDTH bits sharing one clock, one clock enable and one reset. Each channel runs either one-shot or periodic (auto-reload), can be paused, aborted and restarted, and reports remaining count, activity, a one-cycle completion pulse and a sticky event flag with acknowledge. It replaces single-channel countdown instances where several timeouts or tick generators sit in one control block.

---
 rtl/countdown_multi.sv | 119 +++++++++++
 tb/tb_countdown_multi.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_multi.sv
// Bank of independent WIDTH-bit countdown timers, one-shot or periodic.
// Each channel has its own start/pause/abort controls and sticky event flag.
module countdown_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clkena,
    input  logic [CHANNELS*WIDTH-1:0]   ctrl_time,
    input  logic [CHANNELS-1:0]         ctrl_run,
    input  logic [CHANNELS-1:0]         ctrl_mode,
    input  logic [CHANNELS-1:0]         ctrl_pause,
    input  logic [CHANNELS-1:0]         ctrl_abort,
    input  logic [CHANNELS-1:0]         ctrl_ack,
    output logic [CHANNELS*WIDTH-1:0]   stat_left,
    output logic [CHANNELS-1:0]         stat_busy,
    output logic [CHANNELS-1:0]         stat_done,
    output logic [CHANNELS-1:0]         stat_flag,
    output logic                        stat_busy_any,
    output logic                        stat_flag_any
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] r_per;
        logic             r_mode;
        logic             r_busy;
        logic             r_done;
        logic             r_flag;

        logic [WIDTH-1:0] w_time;
        logic [WIDTH-1:0] w_cnt_nxt;
        logic [WIDTH-1:0] w_per_nxt;
        logic             w_mode_nxt;
        logic             w_busy_nxt;
        logic             w_done_nxt;
        logic             w_flag_nxt;

        assign w_time = ctrl_time[g*WIDTH +: WIDTH];

        always_comb begin
            w_cnt_nxt  = r_cnt;
            w_per_nxt  = r_per;
            w_mode_nxt = r_mode;
            w_busy_nxt = r_busy;
            w_done_nxt = 1'b0;
            if (clkena) begin
                if (!r_busy) begin
                    // A zero interval completes at once and never arms.
                    if (ctrl_run[g]) begin
                        if (w_time == ZERO) begin
                            w_cnt_nxt  = ZERO;
                            w_done_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt  = w_time;
                            w_per_nxt  = w_time;
                            w_mode_nxt = ctrl_mode[g];
                            w_busy_nxt = 1'b1;
                        end
                    end
                end else if (ctrl_abort[g]) begin
                    w_cnt_nxt  = ZERO;
                    w_busy_nxt = 1'b0;
                end else if (!ctrl_pause[g]) begin
                    if (r_cnt == ONE) begin
                        w_done_nxt = 1'b1;
                        if (r_mode) begin
                            w_cnt_nxt = r_per;
                        end else begin
                            w_cnt_nxt  = ZERO;
                            w_busy_nxt = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - ONE;
                    end
                end
            end
            // Completion beats acknowledge in the same cycle.
            if (w_done_nxt) begin
                w_flag_nxt = 1'b1;
            end else if (ctrl_ack[g]) begin
                w_flag_nxt = 1'b0;
            end else begin
                w_flag_nxt = r_flag;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt  <= ZERO;
                r_per  <= ZERO;
                r_mode <= 1'b0;
                r_busy <= 1'b0;
                r_done <= 1'b0;
                r_flag <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_nxt;
                r_per  <= w_per_nxt;
                r_mode <= w_mode_nxt;
                r_busy <= w_busy_nxt;
                r_done <= w_done_nxt;
                r_flag <= w_flag_nxt;
            end
        end

        assign stat_left[g*WIDTH +: WIDTH] = r_cnt;
        assign stat_busy[g]                = r_busy;
        assign stat_done[g]                = r_done;
        assign stat_flag[g]                = r_flag;
    end

    assign stat_busy_any = |stat_busy;
    assign stat_flag_any = |stat_flag;

endmodule

// File: tb/tb_countdown_multi.sv
// Bench for countdown_multi: directed scenarios plus randomized traffic
// compared against a per-channel behavioural timer model.
module tb_countdown_multi;

    localparam int W  = 8;
    localparam int CH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            clkena;
    logic [CH*W-1:0] ctrl_time;
    logic [CH-1:0]   ctrl_run;
    logic [CH-1:0]   ctrl_mode;
    logic [CH-1:0]   ctrl_pause;
    logic [CH-1:0]   ctrl_abort;
    logic [CH-1:0]   ctrl_ack;
    logic [CH*W-1:0] stat_left;
    logic [CH-1:0]   stat_busy;
    logic [CH-1:0]   stat_done;
    logic [CH-1:0]   stat_flag;
    logic            stat_busy_any;
    logic            stat_flag_any;

    int total = 0;
    int bad   = 0;

    // Behavioural model: remaining ticks, whether armed, reload value.
    int m_left [CH];
    int m_per  [CH];
    bit m_armed[CH];
    bit m_rep  [CH];
    bit m_done [CH];
    bit m_flag [CH];

    countdown_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk(clk), .reset(reset), .clkena(clkena),
        .ctrl_time(ctrl_time), .ctrl_run(ctrl_run),
        .ctrl_mode(ctrl_mode), .ctrl_pause(ctrl_pause),
        .ctrl_abort(ctrl_abort), .ctrl_ack(ctrl_ack),
        .stat_left(stat_left), .stat_busy(stat_busy),
        .stat_done(stat_done), .stat_flag(stat_flag),
        .stat_busy_any(stat_busy_any),
        .stat_flag_any(stat_flag_any)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, total=%0d", total);
        $fatal(1, "watchdog");
    end

    task automatic model_edge();
        for (int i = 0; i < CH; i++) begin
            bit fin;
            int t;
            fin = 0;
            t = int'(ctrl_time[i*W +: W]);
            if (reset) begin
                m_left[i] = 0; m_per[i] = 0; m_armed[i] = 0;
                m_rep[i] = 0; m_done[i] = 0; m_flag[i] = 0;
                continue;
            end
            if (clkena) begin
                if (!m_armed[i]) begin
                    if (ctrl_run[i] && t == 0) begin
                        fin = 1;
                    end else if (ctrl_run[i]) begin
                        m_left[i] = t; m_per[i] = t;
                        m_rep[i] = ctrl_mode[i]; m_armed[i] = 1;
                    end
                end else if (ctrl_abort[i]) begin
                    m_left[i] = 0; m_armed[i] = 0;
                end else if (!ctrl_pause[i]) begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) begin
                        fin = 1;
                        if (m_rep[i]) m_left[i] = m_per[i];
                        else m_armed[i] = 0;
                    end
                end
            end
            m_done[i] = fin;
            if (fin) m_flag[i] = 1;
            else if (ctrl_ack[i]) m_flag[i] = 0;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; clkena = 1; ctrl_time = '0; ctrl_run = '0;
        ctrl_mode = '0; ctrl_pause = '0; ctrl_abort = '0; ctrl_ack = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({stat_left, stat_busy, stat_done, stat_flag} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h/%b/%b/%b want all 0",
                     stat_left, stat_busy, stat_done, stat_flag);
        end
        total++;
        if ({stat_busy_any, stat_flag_any} !== 2'b00) begin
            bad++;
            $display("FAIL reset_any: got %b want 00",
                     {stat_busy_any, stat_flag_any});
        end
    endtask

    task automatic test_oneshot();
        do_reset();
        ctrl_time[0 +: W] = 8'd5;
        ctrl_run[0] = 1;
        step();
        ctrl_run[0] = 0;
        for (int k = 5; k >= 1; k--) begin
            total++;
            if (stat_left[0 +: W] !== W'(k) || stat_busy[0] !== 1'b1
                || stat_done[0] !== 1'b0) begin
                bad++;
                $display("FAIL oneshot_count: left=%0d busy=%b done=%b want %0d/1/0",
                         stat_left[0 +: W], stat_busy[0], stat_done[0], k);
            end
            if (k > 1) step();
        end
        step();
        total++;
        if (stat_done[0] !== 1'b1 || stat_busy[0] !== 1'b0
            || stat_left[0 +: W] !== 8'd0 || stat_flag[0] !== 1'b1) begin
            bad++;
            $display("FAIL oneshot_end: done=%b busy=%b left=%0d flag=%b want 1/0/0/1",
                     stat_done[0], stat_busy[0], stat_left[0 +: W], stat_flag[0]);
        end
        step();
        step();
        total++;
        if (stat_done[0] !== 1'b0 || stat_flag[0] !== 1'b1
            || stat_flag_any !== 1'b1) begin
            bad++;
            $display("FAIL oneshot_sticky: done=%b flag=%b any=%b want 0/1/1",
                     stat_done[0], stat_flag[0], stat_flag_any);
        end
        ctrl_ack[0] = 1;
        step();
        ctrl_ack[0] = 0;
        total++;
        if (stat_flag[0] !== 1'b0 || stat_flag_any !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_ack: flag=%b any=%b want 0/0",
                     stat_flag[0], stat_flag_any);
        end
    endtask

    task automatic test_periodic();
        do_reset();
        ctrl_time[W +: W] = 8'd3;
        ctrl_mode[1] = 1;
        ctrl_run[1] = 1;
        for (int c = 1; c <= 10; c++) begin
            bit exp_d;
            int exp_l;
            exp_d = (c == 4 || c == 7 || c == 10);
            exp_l = 3 - ((c - 1) % 3);
            ctrl_ack[1] = (c == 10);
            step();
            ctrl_run[1] = 0;
            ctrl_ack[1] = 0;
            total++;
            if (stat_done[1] !== exp_d || stat_left[W +: W] !== W'(exp_l)
                || stat_busy[1] !== 1'b1) begin
                bad++;
                $display("FAIL periodic_c%0d: done=%b left=%0d busy=%b want %b/%0d/1",
                         c, stat_done[1], stat_left[W +: W], stat_busy[1],
                         exp_d, exp_l);
            end
        end
        total++;
        if (stat_flag[1] !== 1'b1) begin
            bad++;
            $display("FAIL periodic_ack_vs_set: flag=%b want 1", stat_flag[1]);
        end
        ctrl_abort[1] = 1;
        step();
        ctrl_abort[1] = 0;
        total++;
        if (stat_busy[1] !== 1'b0 || stat_left[W +: W] !== 8'd0
            || stat_done[1] !== 1'b0 || stat_busy_any !== 1'b0) begin
            bad++;
            $display("FAIL periodic_abort: busy=%b left=%0d done=%b any=%b want 0/0/0/0",
                     stat_busy[1], stat_left[W +: W], stat_done[1], stat_busy_any);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            total++;
            if (stat_done[1] !== 1'b0) begin
                bad++;
                $display("FAIL periodic_after_abort: done=%b want 0", stat_done[1]);
            end
        end
    endtask

    task automatic test_pause_clkena();
        bit pz[8] = '{0, 0, 1, 1, 0, 0, 0, 0};
        bit en[8] = '{1, 1, 1, 1, 0, 1, 0, 1};
        int lf[8] = '{3, 2, 2, 2, 2, 1, 1, 0};
        do_reset();
        ctrl_time[2*W +: W] = 8'd4;
        ctrl_run[2] = 1;
        step();
        ctrl_run[2] = 0;
        for (int k = 0; k < 8; k++) begin
            ctrl_pause[2] = pz[k];
            clkena = en[k];
            step();
            total++;
            if (stat_done[2] !== (k == 7) || stat_left[2*W +: W] !== W'(lf[k])) begin
                bad++;
                $display("FAIL pause_ena_e%0d: done=%b left=%0d want %b/%0d",
                         k + 2, stat_done[2], stat_left[2*W +: W], k == 7, lf[k]);
            end
        end
        ctrl_pause[2] = 0;
        clkena = 1;
    endtask

    task automatic test_zero_and_max();
        int seen;
        do_reset();
        ctrl_run[3] = 1;
        step();
        ctrl_run[3] = 0;
        total++;
        if (stat_busy[3] !== 1'b0 || stat_done[3] !== 1'b1
            || stat_flag[3] !== 1'b1 || stat_left[3*W +: W] !== 8'd0) begin
            bad++;
            $display("FAIL zero_time: busy=%b done=%b flag=%b left=%0d want 0/1/1/0",
                     stat_busy[3], stat_done[3], stat_flag[3], stat_left[3*W +: W]);
        end
        ctrl_time[0 +: W] = 8'd255;
        ctrl_run[0] = 1;
        step();
        ctrl_run[0] = 0;
        seen = 0;
        for (int k = 1; k <= 300 && seen == 0; k++) begin
            if (stat_done[0] === 1'b1) seen = k;
            else step();
        end
        total++;
        if (seen != 256) begin
            bad++;
            $display("FAIL max_time: done at edge %0d want 256", seen);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ctrl_time = {8'd4, 8'd3, 8'd2, 8'd1};
        ctrl_run = 4'hF;
        step();
        total++;
        if (stat_left !== {8'd4, 8'd3, 8'd2, 8'd1} || stat_busy !== 4'hF) begin
            bad++;
            $display("FAIL multi_start: left=%h busy=%b want 04030201/1111",
                     stat_left, stat_busy);
        end
        ctrl_time = {8'd9, 8'd9, 8'd9, 8'd9};
        step();
        total++;
        if (stat_left !== {8'd3, 8'd2, 8'd1, 8'd0} || stat_busy !== 4'b1110
            || stat_done !== 4'b0001) begin
            bad++;
            $display("FAIL rerun_ignored: left=%h busy=%b done=%b want 03020100/1110/0001",
                     stat_left, stat_busy, stat_done);
        end
        reset = 1;
        step();
        reset = 0;
        ctrl_run = '0;
        total++;
        if ({stat_left, stat_busy, stat_done, stat_flag} !== '0
            || stat_busy_any !== 1'b0 || stat_flag_any !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: left=%h busy=%b done=%b flag=%b want all 0",
                     stat_left, stat_busy, stat_done, stat_flag);
        end
    endtask

    task automatic test_random();
        logic [CH*W-1:0] e_left;
        logic [CH-1:0]   e_busy, e_done, e_flag;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            clkena = ($urandom_range(0, 9) < 8);
            for (int i = 0; i < CH; i++) begin
                ctrl_time[i*W +: W] = ($urandom_range(0, 9) == 0) ? 8'd0
                                      : 8'($urandom_range(1, 7));
                ctrl_run[i]   = ($urandom_range(0, 3) == 0);
                ctrl_mode[i]  = $urandom_range(0, 1) == 1;
                ctrl_pause[i] = ($urandom_range(0, 5) == 0);
                ctrl_abort[i] = ($urandom_range(0, 19) == 0);
                ctrl_ack[i]   = ($urandom_range(0, 4) == 0);
            end
            reset = ($urandom_range(0, 199) == 0);
            step();
            for (int i = 0; i < CH; i++) begin
                e_left[i*W +: W] = W'(m_left[i]);
                e_busy[i] = m_armed[i];
                e_done[i] = m_done[i];
                e_flag[i] = m_flag[i];
            end
            total++;
            if (stat_left !== e_left || stat_busy !== e_busy
                || stat_done !== e_done || stat_flag !== e_flag
                || stat_busy_any !== |e_busy || stat_flag_any !== |e_flag) begin
                bad++;
                $display("FAIL random_c%0d: left=%h busy=%b done=%b flag=%b want %h/%b/%b/%b",
                         c, stat_left, stat_busy, stat_done, stat_flag,
                         e_left, e_busy, e_done, e_flag);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause_clkena();
        test_zero_and_max();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
